ex_mdu_stage: RTL
=================

EX_MDU_STAGE -- requirements
Module: ex_mdu_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 and 64.
REQ-002 Parameter TAG_WIDTH, default 4: rd tag width.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 stall_E / flush_E  in  1 each  stage stall / stage flush.
REQ-006 ready_mem  in  1  MEM stage can accept.
REQ-007 ready_ex  out  1  EX instruction advances this cycle.
REQ-008 mdu_en_ex  in  1  instruction is M-extension.
REQ-009 mdu_op_ex  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 src_a_ex / src_b_ex  in  XLEN  rs1 / rs2 operands.
REQ-011 alu_result_ex  in  XLEN  result for non-MDU instructions.
REQ-012 rd_wr_en_ex / rd_wr_tag_ex / rd_wr_addr_ex  in  1 / TAG_WIDTH / 5  destination info.
REQ-013 rd_wr_en_mem / rd_wr_tag_mem / rd_wr_addr_mem / rd_wr_data_mem  out  1 / TAG_WIDTH / 5 / XLEN  EX/MEM register.
REQ-014 forward_ex_en / forward_ex_tag / forward_ex_addr / forward_ex_wdata  out  1 / TAG_WIDTH / 5 / XLEN  EX bypass.
REQ-015 mdu_busy  out  1  FSM not IDLE.

Function
REQ-016 FSM states IDLE, CALC, DONE; mdu_busy = (state != IDLE).
REQ-017 IDLE, mdu_en_ex=1, stall_E=0, flush_E=0: latch operands/op, counter <= XLEN-1, go CALC; ready_ex=0.
REQ-018 IDLE, mdu_en_ex=1, op DIV/DIVU/REM/REMU with src_b_ex=0: go DONE directly, no CALC.
REQ-019 IDLE, op DIV/REM, src_a_ex=-2^(XLEN-1), src_b_ex=-1: go DONE directly.
REQ-020 CALC: one radix-2 iteration per cycle (shift-add multiply, restoring divide on magnitudes); counter decrements; at counter=0 go DONE.
REQ-021 Normal MDU latency: XLEN+2 cycles in EX (entry cycle + XLEN CALC + 1 DONE) when unstalled.
REQ-022 Multiply: full 2*XLEN product; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits; signs per op, sign correction applied once in DONE.
REQ-023 Divide: quotient sign = sign(a)^sign(b), remainder sign = sign(a) for signed ops; truncation toward zero.
REQ-024 Divide by zero: quotient all ones, remainder = src_a.
REQ-025 Signed overflow: quotient = src_a, remainder 0.
REQ-026 DONE: result held in register; ready_ex = ~stall_E & ready_mem; on ready_ex go IDLE; otherwise stay DONE, result stable.
REQ-027 Non-MDU instruction (mdu_en_ex=0, IDLE): ready_ex = ~stall_E & ready_mem, result = alu_result_ex, zero added latency.
REQ-028 IDLE/CALC with mdu_en_ex=1: ready_ex=0.
REQ-029 flush_E in any state: FSM to IDLE, counter cleared, partial result discarded, next-cycle ready_ex governed by REQ-027/028.
REQ-030 EX/MEM register: ready_ex=1 & flush_E=0 -> load rd info and result; ready_ex=1 & flush_E=1 -> bubble; ready_ex=0 & ready_mem=1 -> bubble; ready_mem=0 -> hold.
REQ-031 Bubble: rd_wr_en_mem=0, rd_wr_addr_mem=0, rd_wr_data_mem=0, rd_wr_tag_mem=0.
REQ-032 forward_ex_en = rd_wr_en_ex & ready_ex & ~flush_E; tag/addr = *_ex; wdata = selected result.
REQ-033 Operands on src_*_ex ignored after entry cycle; upstream holds instruction while ready_ex=0.
REQ-034 XLEN=64: identical behaviour, CALC length 64.

Reset
REQ-035 reset_n=0 asynchronously: state IDLE, counter 0, internal accumulators 0, all *_mem outputs 0, mdu_busy 0.
REQ-036 Reset mid-CALC aborts operation; no result reaches MEM.

Verification
REQ-037 XLEN=32, MUL a=7, b=-3 (0xFFFFFFFD), rd=5 -> ready_ex high cycle 34 after entry; rd_wr_data_mem=0xFFFFFFEB, rd_wr_addr_mem=5.
REQ-038 DIVU a=100, b=0 -> DONE next cycle, quotient 0xFFFFFFFF; REMU same -> 100; latency 2 cycles.
REQ-039 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0; latency 2 cycles.
REQ-040 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; flush_E asserted at CALC cycle 10 -> IDLE next cycle, bubble in MEM, no forward_ex_en.
REQ-041 DIV -7/2 in DONE with ready_mem=0 for 3 cycles -> result 0xFFFFFFFD held, MEM held; advances cycle ready_mem rises; REM -7/2 -> 0xFFFFFFFF.
REQ-042 Back-to-back non-MDU ops, ready_mem=1 -> one per cycle, forward_ex_en=1 each, data = alu_result_ex.

Source files
------------

// File: rtl/ex_mdu_stage.sv
// EX stage with an iterative radix-2 multiply/divide unit and the EX/MEM pipeline register.
// Non-MDU instructions pass through with no added latency; MDU ops hold EX until the result is ready.
module ex_mdu_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall_E,
  input  logic                 flush_E,
  input  logic                 ready_mem,
  output logic                 ready_ex,
  input  logic                 mdu_en_ex,
  input  logic [2:0]           mdu_op_ex,
  input  logic [XLEN-1:0]      src_a_ex,
  input  logic [XLEN-1:0]      src_b_ex,
  input  logic [XLEN-1:0]      alu_result_ex,
  input  logic                 rd_wr_en_ex,
  input  logic [TAG_WIDTH-1:0] rd_wr_tag_ex,
  input  logic [4:0]           rd_wr_addr_ex,
  output logic                 rd_wr_en_mem,
  output logic [TAG_WIDTH-1:0] rd_wr_tag_mem,
  output logic [4:0]           rd_wr_addr_mem,
  output logic [XLEN-1:0]      rd_wr_data_mem,
  output logic                 forward_ex_en,
  output logic [TAG_WIDTH-1:0] forward_ex_tag,
  output logic [4:0]           forward_ex_addr,
  output logic [XLEN-1:0]      forward_ex_wdata,
  output logic                 mdu_busy
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic [2:0]          r_op;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic [XLEN-1:0]     r_result;

  logic                w_is_div;
  logic                w_a_sgn;
  logic                w_b_sgn;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_div_zero;
  logic                w_ovf;
  logic [XLEN-1:0]     w_special_res;
  logic [XLEN:0]       w_mul_sum;
  logic [XLEN:0]       w_div_tmp;
  logic [XLEN:0]       w_div_diff;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [2*XLEN-1:0]   w_prod_fix;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_final;
  logic [XLEN-1:0]     w_result_sel;

  // Operand decode for the entry cycle: signedness per op, magnitudes, special divide cases
  always_comb begin
    w_is_div      = mdu_op_ex[2];
    w_a_sgn       = w_is_div ? ~mdu_op_ex[0] : (mdu_op_ex != 3'b011);
    w_b_sgn       = w_is_div ? ~mdu_op_ex[0] : ~mdu_op_ex[1];
    w_a_neg       = w_a_sgn & src_a_ex[XLEN-1];
    w_b_neg       = w_b_sgn & src_b_ex[XLEN-1];
    w_a_mag       = w_a_neg ? -src_a_ex : src_a_ex;
    w_b_mag       = w_b_neg ? -src_b_ex : src_b_ex;
    w_div_zero    = w_is_div & (src_b_ex == '0);
    w_ovf         = w_is_div & ~mdu_op_ex[0] & (src_a_ex == {1'b1, {(XLEN-1){1'b0}}})
                    & (&src_b_ex);
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = mdu_op_ex[1] ? src_a_ex : '1;
    end else begin
      w_special_res = mdu_op_ex[1] ? '0 : src_a_ex;
    end
  end

  // One radix-2 step: shift-add multiply on {acc_hi, multiplier}, restoring divide on {rem, quo}
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_tmp  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_div_diff = w_div_tmp - {1'b0, r_opnd};
    if (r_op[2]) begin
      w_acc_next = w_div_diff[XLEN] ? {w_div_tmp[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                    : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end else begin
      w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
    end
  end

  // Sign correction and result selection, applied once on the last iteration
  always_comb begin
    w_prod_fix = r_neg_res ? -w_acc_next : w_acc_next;
    w_quo      = r_neg_res ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    w_rem      = r_neg_rem ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
    w_final    = '0;
    case (r_op)
      3'b000:         w_final = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         w_final = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: w_final = w_quo;
      default:        w_final = w_rem;
    endcase
  end

  always_comb begin
    ready_ex = 1'b0;
    case (r_state)
      S_IDLE:  ready_ex = ~mdu_en_ex & ~stall_E & ready_mem;
      S_DONE:  ready_ex = ~stall_E & ready_mem;
      default: ready_ex = 1'b0;
    endcase
  end

  assign mdu_busy         = (r_state != S_IDLE);
  assign w_result_sel     = (r_state == S_DONE) ? r_result : alu_result_ex;
  assign forward_ex_en    = rd_wr_en_ex & ready_ex & ~flush_E;
  assign forward_ex_tag   = rd_wr_tag_ex;
  assign forward_ex_addr  = rd_wr_addr_ex;
  assign forward_ex_wdata = w_result_sel;

  // MDU control FSM and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_op      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else if (flush_E) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mdu_en_ex && !stall_E) begin
            r_op      <= mdu_op_ex;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            if (w_div_zero || w_ovf) begin
              r_result <= w_special_res;
              r_state  <= S_DONE;
            end else begin
              r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
              r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
              r_cnt   <= CW'(XLEN - 1);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          if (r_cnt == '0) begin
            r_result <= w_final;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (ready_ex) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // EX/MEM register: load on advance, bubble when EX does not advance, hold when MEM is stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wr_en_mem   <= 1'b0;
      rd_wr_tag_mem  <= '0;
      rd_wr_addr_mem <= '0;
      rd_wr_data_mem <= '0;
    end else if (ready_mem) begin
      if (ready_ex && !flush_E) begin
        rd_wr_en_mem   <= rd_wr_en_ex;
        rd_wr_tag_mem  <= rd_wr_tag_ex;
        rd_wr_addr_mem <= rd_wr_addr_ex;
        rd_wr_data_mem <= w_result_sel;
      end else begin
        rd_wr_en_mem   <= 1'b0;
        rd_wr_tag_mem  <= '0;
        rd_wr_addr_mem <= '0;
        rd_wr_data_mem <= '0;
      end
    end
  end

endmodule
